ysyx_23060332_mem_arbiter: RTL and testbench

YSYX_23060332_MEM_ARBITER -- requirements
Module: ysyx_23060332_mem_arbiter

---
 rtl/ysyx_23060332_mem_arbiter_if.sv | 46 ++++
 rtl/ysyx_23060332_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_ysyx_23060332_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060332_mem_arbiter_if.sv
// rtl/ysyx_23060332_mem_arbiter_if.sv - IFU/LSU request ports and shared memory port bundle
interface ysyx_23060332_mem_arbiter_if;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_gnt;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        ifu_err;

  logic        lsu_req;
  logic        lsu_we;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_gnt;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  ifu_req, ifu_addr,
    output ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output ifu_req, ifu_addr,
    input  ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/ysyx_23060332_mem_arbiter.sv
// rtl/ysyx_23060332_mem_arbiter.sv - round-robin IFU/LSU arbiter onto one memory port
// One outstanding transaction; a cycle budget aborts accesses the memory never finishes.
module ysyx_23060332_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_23060332_mem_arbiter_if.master bus,
  output logic                       busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;
  localparam logic [15:0] TMO     = 16'(TIMEOUT_CYC);
  localparam logic        OWN_IFU = 1'b0;
  localparam logic        OWN_LSU = 1'b1;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ifu_gnt_q, ifu_gnt_d, lsu_gnt_q, lsu_gnt_d;
  logic        ifu_rvalid_q, ifu_rvalid_d, lsu_rvalid_q, lsu_rvalid_d;
  logic        ifu_err_q, ifu_err_d, lsu_err_q, lsu_err_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;

  logic        any_req, winner, active, issue, done, expired;
  logic [15:0] cnt_inc;

  assign any_req = bus.ifu_req | bus.lsu_req;
  // On a tie the side not served last wins
  assign winner  = (bus.ifu_req & bus.lsu_req) ? ~last_q : bus.lsu_req;
  assign issue   = (state_q == ISSUE);
  assign active  = issue || (state_q == WAIT);
  assign cnt_inc = cnt_q + 16'd1;
  assign done    = (state_q == WAIT) & bus.mem_rvalid;
  assign expired = active & (cnt_inc == TMO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      last_q       <= OWN_IFU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      cnt_q        <= '0;
      ifu_gnt_q    <= 1'b0;
      lsu_gnt_q    <= 1'b0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      ifu_err_q    <= 1'b0;
      lsu_err_q    <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      cnt_q        <= cnt_d;
      ifu_gnt_q    <= ifu_gnt_d;
      lsu_gnt_q    <= lsu_gnt_d;
      ifu_rvalid_q <= ifu_rvalid_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      ifu_err_q    <= ifu_err_d;
      lsu_err_q    <= lsu_err_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (expired) state_d = IDLE; else if (bus.mem_gnt) state_d = WAIT;
      WAIT:    if (done || expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : datapath
    owner_d      = owner_q;
    last_d       = last_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    cnt_d        = cnt_q;
    ifu_gnt_d    = 1'b0;
    lsu_gnt_d    = 1'b0;
    ifu_rvalid_d = 1'b0;
    lsu_rvalid_d = 1'b0;
    ifu_err_d    = 1'b0;
    lsu_err_d    = 1'b0;
    ifu_rdata_d  = ifu_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;
    if ((state_q == IDLE) && any_req) begin
      owner_d = winner;
      last_d  = winner;
      cnt_d   = '0;
      if (winner == OWN_LSU) begin
        we_d      = bus.lsu_we;
        addr_d    = bus.lsu_addr;
        wdata_d   = bus.lsu_wdata;
        wmask_d   = bus.lsu_wmask;
        lsu_gnt_d = 1'b1;
      end else begin
        we_d      = 1'b0;
        addr_d    = bus.ifu_addr;
        wdata_d   = '0;
        wmask_d   = '0;
        ifu_gnt_d = 1'b1;
      end
    end else if (active) begin
      cnt_d = cnt_inc;
      // A completion on the expiry edge still counts as a normal completion
      if (done || expired) begin
        if (owner_q == OWN_LSU) begin
          lsu_rvalid_d = 1'b1;
          lsu_err_d    = ~done;
          lsu_rdata_d  = (done && !we_q) ? bus.mem_rdata : '0;
        end else begin
          ifu_rvalid_d = 1'b1;
          ifu_err_d    = ~done;
          ifu_rdata_d  = done ? bus.mem_rdata : '0;
        end
      end
    end
  end

  always_comb begin : outputs
    busy           = (state_q != IDLE);
    bus.mem_req    = issue;
    bus.mem_we     = issue & we_q;
    bus.mem_addr   = issue ? addr_q : '0;
    bus.mem_wdata  = issue ? wdata_q : '0;
    bus.mem_wmask  = issue ? wmask_q : '0;
    bus.ifu_gnt    = ifu_gnt_q;
    bus.lsu_gnt    = lsu_gnt_q;
    bus.ifu_rvalid = ifu_rvalid_q;
    bus.lsu_rvalid = lsu_rvalid_q;
    bus.ifu_err    = ifu_err_q;
    bus.lsu_err    = lsu_err_q;
    bus.ifu_rdata  = ifu_rdata_q;
    bus.lsu_rdata  = lsu_rdata_q;
  end
endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// tb/tb_ysyx_23060332_mem_arbiter.sv - scoreboard bench for the IFU/LSU memory arbiter
// Stimulus pushes expected grants/completions; a negedge monitor pops and compares.
module tb_ysyx_23060332_mem_arbiter;
  localparam int TMO = 4;

  typedef struct {
    bit          owner;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    bit          err;
    logic [31:0] rdata;
    logic [31:0] oth_rdata;
    int          gnt_cyc;
    int          rv_cyc;
    bit          aborted;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          last_lsu;
  logic [31:0] held [2];
  exp_t        exp_q [$];
  exp_t        mon_e;

  ysyx_23060332_mem_arbiter_if bus ();

  ysyx_23060332_mem_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    last_lsu = 1'b0;
    held[0]  = '0;
    held[1]  = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {bus.ifu_gnt, bus.ifu_rvalid, bus.ifu_err, bus.lsu_gnt, bus.lsu_rvalid,
                         bus.lsu_err, bus.mem_req, bus.mem_we, busy}, 0);
    chk({tag, "_ifu_rdata"}, bus.ifu_rdata, 0);
    chk({tag, "_lsu_rdata"}, bus.lsu_rdata, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, {bus.mem_wdata, bus.mem_wmask}, 0);
  endtask

  // g: ISSUE cycles memory stalls before mem_gnt; r: WAIT cycles before mem_rvalid
  task automatic txn(input bit ir, input bit lr, input logic [31:0] ia, input bit lwe,
                     input logic [31:0] la, input logic [31:0] lwd, input logic [7:0] lwm,
                     input int g, input int r, input logic [31:0] rd, input bit stray);
    exp_t e;
    bit   w;
    int   n;
    int   full;
    w        = (ir && lr) ? !last_lsu : lr;
    last_lsu = w;
    full     = g + r + 2;
    n        = (full <= TMO) ? full : TMO;
    e.owner     = w;
    e.we        = w & lwe;
    e.addr      = w ? la : ia;
    e.wdata     = w ? lwd : 32'h0;
    e.wmask     = w ? lwm : 8'h0;
    e.err       = (full > TMO);
    e.rdata     = (e.err || e.we) ? 32'h0 : rd;
    held[w]     = e.rdata;
    e.oth_rdata = held[!w];
    e.gnt_cyc   = cyc + 1;
    e.rv_cyc    = cyc + 1 + n;
    e.aborted   = 1'b0;
    exp_q.push_back(e);

    bus.ifu_req    = ir;
    bus.ifu_addr   = ia;
    bus.lsu_req    = lr;
    bus.lsu_we     = lwe;
    bus.lsu_addr   = la;
    bus.lsu_wdata  = lwd;
    bus.lsu_wmask  = lwm;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    tick();
    for (int k = 1; k <= n; k++) begin
      if (k == 1) begin
        chk("busy_active", busy, 1);
        if (w) bus.lsu_req = 1'b0;
        else bus.ifu_req = 1'b0;
      end
      bus.mem_gnt    = (k == g + 1);
      bus.mem_rvalid = (k == full) || (stray && (k <= g + 1) && ($urandom_range(0, 1) == 1));
      bus.mem_rdata  = (k == full) ? rd : $urandom;
      tick();
    end
    bus.ifu_req    = 1'b0;
    bus.lsu_req    = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    chk("busy_idle", busy, 0);
  endtask

  task automatic gap(input int m, input bit force_rv);
    for (int k = 0; k < m; k++) begin
      bus.mem_rvalid = force_rv || ($urandom_range(0, 1) == 1);
      bus.mem_rdata  = $urandom;
      tick();
    end
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic abort_txn();
    exp_t e;
    last_lsu    = 1'b0;
    e.owner     = 1'b0;
    e.we        = 1'b0;
    e.addr      = 32'h8000_2000;
    e.wdata     = 32'h0;
    e.wmask     = 8'h0;
    e.err       = 1'b0;
    e.rdata     = 32'h0;
    e.oth_rdata = 32'h0;
    e.gnt_cyc   = cyc + 1;
    e.rv_cyc    = 0;
    e.aborted   = 1'b1;
    exp_q.push_back(e);
    bus.ifu_req  = 1'b1;
    bus.ifu_addr = 32'h8000_2000;
    tick();
    bus.ifu_req = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    chk("busy_wait", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_zero("abort");
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    tick();
    bus.mem_rvalid = 1'b0;
    check_zero("abort_late_rvalid");
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ifu_gnt || bus.lsu_gnt) begin
        if (exp_q.size() == 0) begin
          chk("gnt_unexpected", {bus.ifu_gnt, bus.lsu_gnt}, 0);
        end else begin
          mon_e = exp_q[0];
          chk("gnt_owner", {bus.ifu_gnt, bus.lsu_gnt}, mon_e.owner ? 2'b01 : 2'b10);
          chk("gnt_cycle", cyc, mon_e.gnt_cyc);
          chk("mem_req_we", {bus.mem_req, bus.mem_we}, {1'b1, mon_e.we});
          chk("mem_addr", bus.mem_addr, mon_e.addr);
          chk("mem_wdata_wmask", {bus.mem_wdata, bus.mem_wmask}, {mon_e.wdata, mon_e.wmask});
          if (mon_e.aborted) void'(exp_q.pop_front());
        end
      end
      if (bus.ifu_rvalid || bus.lsu_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", {bus.ifu_rvalid, bus.lsu_rvalid}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rv_owner", {bus.ifu_rvalid, bus.lsu_rvalid}, mon_e.owner ? 2'b01 : 2'b10);
          chk("rv_cycle", cyc, mon_e.rv_cyc);
          chk("rv_err", {bus.ifu_err, bus.lsu_err},
              mon_e.owner ? {1'b0, mon_e.err} : {mon_e.err, 1'b0});
          chk("rv_rdata", mon_e.owner ? bus.lsu_rdata : bus.ifu_rdata, mon_e.rdata);
          chk("held_rdata", mon_e.owner ? bus.ifu_rdata : bus.lsu_rdata, mon_e.oth_rdata);
        end
      end else begin
        chk("err_without_rvalid", {bus.ifu_err, bus.lsu_err}, 0);
      end
      if (!bus.mem_req) begin
        chk("mem_idle_zero", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask}, 0);
      end
    end
  end

  initial begin
    int  p;
    int  g;
    int  r;
    bit  ir;
    bit  lr;
    rst            = 1'b1;
    bus.ifu_req    = 1'b0;
    bus.ifu_addr   = '0;
    bus.lsu_req    = 1'b0;
    bus.lsu_we     = 1'b0;
    bus.lsu_addr   = '0;
    bus.lsu_wdata  = '0;
    bus.lsu_wmask  = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    model_reset();
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Simultaneous requests alternate starting with LSU
    txn(1, 1, 32'h8000_0100, 0, 32'h8000_0200, 32'h1111_1111, 8'hFF, 0, 0, 32'hA000_0001, 0);
    txn(1, 1, 32'h8000_0104, 0, 32'h8000_0204, 32'h2222_2222, 8'hFF, 0, 0, 32'hA000_0002, 0);
    txn(1, 1, 32'h8000_0108, 0, 32'h8000_0208, 32'h3333_3333, 8'hFF, 0, 0, 32'hA000_0003, 0);

    txn(1, 0, 32'h8000_0000, 0, 32'h0, 32'h0, 8'h0, 0, 0, 32'h0000_0413, 0);
    txn(0, 1, 32'h0, 1, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 0, 0, 32'h5555_AAAA, 0);

    // Timeout with the memory never completing, then stray completions in IDLE
    txn(1, 0, 32'h8000_0040, 0, 32'h0, 32'h0, 8'h0, 0, 50, 32'h7777_7777, 0);
    gap(3, 1);

    // Completion exactly on the expiry edge, and expiry in WAIT and in ISSUE
    txn(0, 1, 32'h0, 0, 32'h8000_3000, 32'h0, 8'h3, 1, 1, 32'hCAFE_F00D, 0);
    txn(1, 0, 32'h8000_0044, 0, 32'h0, 32'h0, 8'h0, 2, 1, 32'h0BAD_0BAD, 1);
    txn(0, 1, 32'h0, 0, 32'h8000_3004, 32'h0, 8'h1, 3, 0, 32'h0BAD_0BAD, 1);

    abort_txn();
    txn(1, 1, 32'h8000_0500, 0, 32'h8000_0600, 32'h0, 8'h0, 0, 0, 32'h4242_4242, 0);

    for (int t = 0; t < 300; t++) begin
      p  = $urandom_range(0, 2);
      ir = (p != 1);
      lr = (p != 0);
      g  = $urandom_range(0, 2);
      r  = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 2);
      txn(ir, lr, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
          8'($urandom_range(0, 255)), g, r, $urandom, 1);
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2), 0);
    end

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
